// File: rtl/can_bittime_fd.sv
// CAN / CAN FD bit-timing engine: quantum counter, SJW-limited resynchronisation,
// hard sync, nominal/data timing sets with bit-rate switch, and optional triple sampling.
module can_bittime_fd #(
    parameter int T1W  = 8,
    parameter int T2W  = 6,
    parameter int SJWW = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tq_en,
    input  logic            hardsync,
    input  logic            rx,
    input  logic            phase_sel,
    input  logic            triple_smp,
    input  logic [T1W-1:0]  nom_tseg1,
    input  logic [T2W-1:0]  nom_tseg2,
    input  logic [SJWW-1:0] nom_sjw,
    input  logic [T1W-1:0]  dat_tseg1,
    input  logic [T2W-1:0]  dat_tseg2,
    input  logic [SJWW-1:0] dat_sjw,
    output logic            smplpoint,
    output logic            sendpoint,
    output logic            smpldbit,
    output logic            data_phase,
    output logic [T1W:0]    tq_cnt,
    output logic [1:0]      bitst
);
    localparam int EW = T1W + 2;
    localparam logic [T1W:0] TQ_ONE = 1;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_SYNC = 2'd1,
        ST_SEG1 = 2'd2,
        ST_SEG2 = 2'd3
    } state_t;

    state_t          r_state;
    logic [T1W:0]    r_tq_cnt;
    logic            r_smplpoint, r_sendpoint, r_smpldbit, r_data_phase;
    logic [SJWW-1:0] r_ext, r_shrink;
    logic            r_resync_done, r_rx_q, r_rx_q2;
    logic [T1W-1:0]  r_cfg_tseg1;
    logic [T2W-1:0]  r_cfg_tseg2;
    logic [SJWW-1:0] r_cfg_sjw;

    logic            w_edge, w_hard, w_resync, w_maj, w_bit;
    logic [T1W-1:0]  w_sel_tseg1;
    logic [T2W-1:0]  w_sel_tseg2, w_ph_tseg2;
    logic [SJWW-1:0] w_sel_sjw, w_ph_sjw, w_late_ext, w_ext_eff;
    logic [EW-1:0]   w_e, w_sjw, w_sp_idx, w_end_idx, w_pe;

    // Falling edge seen only while the last sampled bit was recessive.
    assign w_edge   = tq_en & ~rx & r_rx_q & r_smpldbit;
    assign w_hard   = w_edge & hardsync;
    assign w_resync = w_edge & ~hardsync & ~r_resync_done;

    assign w_sel_tseg1 = r_data_phase ? dat_tseg1 : nom_tseg1;
    assign w_sel_tseg2 = r_data_phase ? dat_tseg2 : nom_tseg2;
    assign w_sel_sjw   = r_data_phase ? dat_sjw   : nom_sjw;
    assign w_ph_tseg2  = phase_sel ? dat_tseg2 : nom_tseg2;
    assign w_ph_sjw    = phase_sel ? dat_sjw   : nom_sjw;

    assign w_e        = {1'b0, r_tq_cnt};
    assign w_sjw      = EW'(r_cfg_sjw);
    assign w_late_ext = (w_e < w_sjw) ? SJWW'(r_tq_cnt) : r_cfg_sjw;
    // A late edge on the sample tick itself pushes the sample point out before it is taken.
    assign w_ext_eff  = (r_state == ST_SEG1 && w_resync) ? w_late_ext : r_ext;
    assign w_sp_idx   = EW'(r_cfg_tseg1) + EW'(w_ext_eff);
    assign w_end_idx  = EW'(r_cfg_tseg1) + EW'(r_ext) + EW'(r_cfg_tseg2) - EW'(r_shrink);
    assign w_pe       = w_end_idx - w_e + EW'(1);

    assign w_maj = (rx & r_rx_q) | (rx & r_rx_q2) | (r_rx_q & r_rx_q2);
    assign w_bit = (triple_smp && !r_data_phase) ? w_maj : rx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RST;
            r_tq_cnt      <= '0;
            r_smplpoint   <= 1'b0;
            r_sendpoint   <= 1'b0;
            r_smpldbit    <= 1'b1;
            r_data_phase  <= 1'b0;
            r_ext         <= '0;
            r_shrink      <= '0;
            r_resync_done <= 1'b0;
            r_rx_q        <= 1'b1;
            r_rx_q2       <= 1'b1;
            r_cfg_tseg1   <= '0;
            r_cfg_tseg2   <= '0;
            r_cfg_sjw     <= '0;
        end else begin
            r_smplpoint <= 1'b0;
            r_sendpoint <= 1'b0;
            if (tq_en) begin
                r_rx_q  <= rx;
                r_rx_q2 <= r_rx_q;
                if (w_hard) begin
                    r_state       <= ST_SEG1;
                    r_tq_cnt      <= TQ_ONE;
                    r_sendpoint   <= 1'b1;
                    r_ext         <= '0;
                    r_shrink      <= '0;
                    r_resync_done <= 1'b1;
                    r_cfg_tseg1   <= w_sel_tseg1;
                    r_cfg_tseg2   <= w_sel_tseg2;
                    r_cfg_sjw     <= w_sel_sjw;
                end else begin
                    case (r_state)
                        ST_RST: begin
                            r_state     <= ST_SEG1;
                            r_tq_cnt    <= TQ_ONE;
                            r_cfg_tseg1 <= w_sel_tseg1;
                            r_cfg_tseg2 <= w_sel_tseg2;
                            r_cfg_sjw   <= w_sel_sjw;
                        end
                        ST_SYNC: begin
                            r_state  <= ST_SEG1;
                            r_tq_cnt <= TQ_ONE;
                        end
                        ST_SEG1: begin
                            r_tq_cnt <= r_tq_cnt + TQ_ONE;
                            if (w_resync) begin
                                r_ext         <= w_late_ext;
                                r_resync_done <= 1'b1;
                            end
                            if (w_e == w_sp_idx) begin
                                r_smplpoint   <= 1'b1;
                                r_smpldbit    <= w_bit;
                                r_data_phase  <= phase_sel;
                                r_cfg_tseg2   <= w_ph_tseg2;
                                r_cfg_sjw     <= w_ph_sjw;
                                r_resync_done <= 1'b0;
                                r_state       <= ST_SEG2;
                            end
                        end
                        ST_SEG2: begin
                            if (w_resync && w_pe <= w_sjw) begin
                                // Early edge within SJW reach: this tick becomes the sync segment.
                                r_state       <= ST_SEG1;
                                r_tq_cnt      <= TQ_ONE;
                                r_sendpoint   <= 1'b1;
                                r_ext         <= '0;
                                r_shrink      <= '0;
                                r_resync_done <= 1'b1;
                                r_cfg_tseg1   <= w_sel_tseg1;
                                r_cfg_tseg2   <= w_sel_tseg2;
                                r_cfg_sjw     <= w_sel_sjw;
                            end else begin
                                if (w_resync) begin
                                    r_shrink      <= r_cfg_sjw;
                                    r_resync_done <= 1'b1;
                                end
                                if (w_e >= w_end_idx) begin
                                    r_state     <= ST_SYNC;
                                    r_tq_cnt    <= '0;
                                    r_sendpoint <= 1'b1;
                                    r_ext       <= '0;
                                    r_shrink    <= '0;
                                    r_cfg_tseg1 <= w_sel_tseg1;
                                    r_cfg_tseg2 <= w_sel_tseg2;
                                    r_cfg_sjw   <= w_sel_sjw;
                                end else begin
                                    r_tq_cnt <= r_tq_cnt + TQ_ONE;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign smplpoint  = r_smplpoint;
    assign sendpoint  = r_sendpoint;
    assign smpldbit   = r_smpldbit;
    assign data_phase = r_data_phase;
    assign tq_cnt     = r_tq_cnt;
    assign bitst      = r_state;
endmodule

// File: doc/can_bittime_fd.md
Name: can_bittime_fd

Overview:
- Parametrised successor of the CAN bit-timing FSM, with the time-quantum counter, resynchronisation arithmetic and sampled-bit latch integrated.
- Supports two timing sets: nominal and data (CAN FD bit-rate switch), an SJW-limited phase-error correction computed in-block, and optional triple sampling.
- Sits between the prescaler, which supplies the quantum tick, and the MAC FSM, which consumes smplpoint, sendpoint and smpldbit.

Parameters:
- T1W, 8, width of tseg1 fields and of tq_cnt
- T2W, 6, width of tseg2 fields
- SJWW, 5, width of sjw fields

Ports:
- clock  in  1  system clock
- reset  in  1  async active-low reset
- tq_en  in  1  quantum tick from prescaler; all state advances only on cycles with tq_en=1
- hardsync  in  1  from MAC; next valid edge causes a hard sync
- rx  in  1  CAN bus input, already synchronised
- phase_sel  in  1  0=nominal, 1=data timing; sampled at the sample point
- triple_smp  in  1  majority-of-3 sampling, nominal phase only
- nom_tseg1  in  T1W  nominal prop+phase1 quanta (>=2)
- nom_tseg2  in  T2W  nominal phase2 quanta (>=1)
- nom_sjw  in  SJWW  nominal SJW (1..min(tseg1,tseg2))
- dat_tseg1  in  T1W  data-phase tseg1 (>=1)
- dat_tseg2  in  T2W  data-phase tseg2 (>=1)
- dat_sjw  in  SJWW  data-phase SJW
- smplpoint  out  1  one-clock pulse, sample point reached
- sendpoint  out  1  one-clock pulse, bit boundary; MAC drives the next bit
- smpldbit  out  1  sampled bit value
- data_phase  out  1  active timing set
- tq_cnt  out  T1W+1  current quantum index (debug)
- bitst  out  2  state: 0=RST, 1=SYNC, 2=SEG1, 3=SEG2

Behaviour:
- Reset: state RST; tq_cnt=0; smplpoint=sendpoint=0; smpldbit=1; data_phase=0; ext=shrink=0; resync_done=0; rx_q=1.
- The "tick" is the rising clock edge with tq_en=1. Non-tick cycles hold all state; pulses are 0.
- Active set S = data_phase ? dat_* : nom_*. It is captured into internal cfg registers on entry to SYNC. phase_sel changes the seg2 config immediately at the sample point.
- Quantum indices: 0 = sync seg; 1..tseg1+ext = SEG1; after that, SEG2.
- Bit end index E = tseg1 + ext + tseg2 - shrink. Compute at T1W+2 bits; no wrap.
- RST: the first tick goes to SEG1 with tq_cnt=1.
- SEG1: tq_cnt++ each tick.
  - On the tick where tq_cnt == tseg1+ext: smplpoint=1 and smpldbit updated next clock.
  - data_phase <= phase_sel; resync_done cleared; state goes to SEG2.
- SEG2: on the tick where tq_cnt == E: tq_cnt=0, sendpoint=1 next clock, ext=shrink=0, state SYNC.
- SYNC: the next tick goes to SEG1 with tq_cnt=1.
- Edge definition: edge = tick & rx==0 & rx_q==1 & smpldbit==1. rx_q is rx captured on each tick. The edge lies in quantum e = tq_cnt.
- Hard sync: edge with hardsync=1, in any state including RST.
  - tq_cnt=1, state SEG1, ext=shrink=0, sendpoint pulse, cfg re-captured.
  - Has priority over resync and over a coincident sample or end tick.
- Resync applies only when resync_done=0, and sets resync_done=1.
  - SYNC (e=0): no action.
  - SEG1 (late edge): ext = min(e, sjw). The sample point moves within the same bit.
  - SEG2 (early edge): pe = E - e + 1.
    - If pe <= sjw: this tick ends the bit. tq_cnt=1, state SEG1, sendpoint pulse, ext=shrink=0.
    - Else: shrink = sjw.
  - An edge on the sample tick itself is treated as SEG1 (late).
- Triple sampling (triple_smp=1, data_phase=0): smpldbit = majority of rx at the ticks ending quanta sp-2, sp-1 and sp. Otherwise smpldbit = rx at the sample tick.
- Reset mid-bit returns immediately to the RST values; no pulse is emitted.
- Config changes outside SYNC take effect at the next SYNC, except the phase_sel effect at the sample point described above.

Test Plan:
- Common setup: nom tseg1=5, tseg2=3, sjw=2; tq_en=1 every cycle; rx=1; no edges. Expected: sendpoint every 9 clocks; smplpoint 6 clocks after each sendpoint; tq_cnt sequence 0..8.
- Late edge: rx falls at quantum 3 of a bit -> ext=2; smplpoint at index 7; bit length 11 clocks; next bit 9 clocks.
- Early edge: rx falls at index 7 (pe=2 <= sjw) -> sendpoint next clock, next bit starts at tq_cnt=1, that bit is 8 quanta. Second edge in the same bit -> ignored.
- Hardsync=1 with edge at index 4 -> sendpoint pulse, tq_cnt=1, no smplpoint for the old bit.
- BRS: dat tseg1=2, tseg2=1; phase_sel=1 before the sample point -> data_phase=1 after smplpoint; seg2 lasts 1 quantum; subsequent bits are 4 clocks with smplpoint at index 2.
- Triple sampling: rx=0 only in quantum 4, or tq_en every 3rd cycle -> smpldbit=1 and timing scales x3. Reset asserted at index 6 -> outputs return to reset values immediately; after release, the first tick gives bitst=SEG1.
